// File: rtl/tx_buffer.sv
// Transmit FIFO feeding uart_tx one byte at a time over a tx_start/tx_busy handshake.
// In line mode, bytes are held until a full line (EOL_CHAR) or a flush is queued.
module tx_buffer #(
  parameter int               DEPTH     = 32,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] EOL_CHAR  = 8'h0A,
  parameter int               LINE_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     line_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    lines;
  logic             flush_pending;

  logic wr_accept, drain_ok, pop, wr_eol, pop_eol;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign tx_start  = (state == START);

  assign wr_accept = wr_en && !full;
  assign drain_ok  = !empty && ((LINE_MODE == 0) || (lines != '0) || flush_pending);
  assign pop       = (state == IDLE) && drain_ok;
  assign wr_eol    = wr_accept && (wr_data == EOL_CHAR);
  assign pop_eol   = pop && (mem[rd_ptr] == EOL_CHAR);

  // NOTE: storage array carries no reset; stale entries are unreachable because
  // level/pointers are reset, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      lines         <= '0;
      flush_pending <= 1'b0;
      overflow      <= 1'b0;
      tx_data       <= '0;
      line_sent     <= 1'b0;
      state         <= IDLE;
    end else begin
      state     <= state_n;
      overflow  <= wr_en && full;
      line_sent <= (state == WAIT_LO) && !tx_busy && (tx_data == EOL_CHAR);

      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end

      case ({wr_accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (wr_eol && !pop_eol)      lines <= lines + LW'(1);
      else if (!wr_eol && pop_eol) lines <= lines - LW'(1);

      // The pop that empties the buffer completes a flush.
      if (pop && !wr_accept && (level == LW'(1))) flush_pending <= 1'b0;
      else if (flush && (LINE_MODE != 0))         flush_pending <= 1'b1;
    end
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (drain_ok) state_n = START;
      START:   state_n = WAIT_HI;
      WAIT_HI: if (tx_busy)  state_n = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_buffer.sv
// Directed bench for tx_buffer: one free-draining instance and one line-mode instance,
// each with a small uart_tx busy model.
module tb_tx_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en0, flush0, full0, empty0, overflow0, tx_busy0, tx_start0, line_sent0;
  logic [7:0] wr_data0, tx_data0;
  logic [5:0] level0;
  logic       wr_en1, flush1, full1, empty1, overflow1, tx_busy1, tx_start1, line_sent1;
  logic [7:0] wr_data1, tx_data1;
  logic [5:0] level1;

  logic       model_busy0, model_busy1, hold_busy0;
  int         busy_len = 10;
  int         passed = 0;
  int         total  = 0;
  logic [7:0] sent0[$];
  logic [7:0] sent1[$];
  int         line_cnt0, line_cnt1;

  assign tx_busy0 = model_busy0 | hold_busy0;
  assign tx_busy1 = model_busy1;

  tx_buffer #(.DEPTH(32), .WIDTH(8), .EOL_CHAR(8'h0A), .LINE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .flush(flush0),
    .full(full0), .empty(empty0), .level(level0), .overflow(overflow0),
    .tx_busy(tx_busy0), .tx_start(tx_start0), .tx_data(tx_data0), .line_sent(line_sent0)
  );

  tx_buffer #(.DEPTH(32), .WIDTH(8), .EOL_CHAR(8'h0A), .LINE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .flush(flush1),
    .full(full1), .empty(empty1), .level(level1), .overflow(overflow1),
    .tx_busy(tx_busy1), .tx_start(tx_start1), .tx_data(tx_data1), .line_sent(line_sent1)
  );

  // uart_tx models: busy rises mid-START and stays high for busy_len cycles
  initial begin
    model_busy0 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start0 === 1'b1) begin
        model_busy0 = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy0 = 1'b0;
      end
    end
  end

  initial begin
    model_busy1 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start1 === 1'b1) begin
        model_busy1 = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy1 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_start0 === 1'b1) sent0.push_back(tx_data0);
      if (tx_start1 === 1'b1) sent1.push_back(tx_data1);
      if (line_sent0 === 1'b1) line_cnt0++;
      if (line_sent1 === 1'b1) line_cnt1++;
    end
  end

  task automatic wr0(input logic [7:0] d);
    wr_en0 = 1'b1; wr_data0 = d;
    @(negedge clk);
    wr_en0 = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] d);
    wr_en1 = 1'b1; wr_data1 = d;
    @(negedge clk);
    wr_en1 = 1'b0;
  endtask

  task automatic wait_sent0(input int n);
    int t = 0;
    while (sent0.size() < n && t < 3000) begin @(negedge clk); t++; end
    total++; if (sent0.size() < n) $display("FAIL drain0_timeout got %0d want %0d", sent0.size(), n); else passed++;
    repeat (busy_len + 6) @(negedge clk);
  endtask

  task automatic wait_sent1(input int n);
    int t = 0;
    while (sent1.size() < n && t < 3000) begin @(negedge clk); t++; end
    total++; if (sent1.size() < n) $display("FAIL drain1_timeout got %0d want %0d", sent1.size(), n); else passed++;
    repeat (busy_len + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en0 = 0; wr_data0 = 0; flush0 = 0; hold_busy0 = 0;
    wr_en1 = 0; wr_data1 = 0; flush1 = 0;
    repeat (2) @(negedge clk);
    total++; if (empty0 !== 1'b1)   $display("FAIL rst_empty got %b want 1", empty0); else passed++;
    total++; if (full0 !== 1'b0)    $display("FAIL rst_full got %b want 0", full0); else passed++;
    total++; if (level0 !== 6'd0)   $display("FAIL rst_level got %0d want 0", level0); else passed++;
    total++; if (tx_start0 !== 1'b0) $display("FAIL rst_tx_start got %b want 0", tx_start0); else passed++;
    total++; if (tx_data0 !== 8'h00) $display("FAIL rst_tx_data got %h want 00", tx_data0); else passed++;
    total++; if (line_sent0 !== 1'b0) $display("FAIL rst_line_sent got %b want 0", line_sent0); else passed++;
    total++; if (overflow0 !== 1'b0) $display("FAIL rst_overflow got %b want 0", overflow0); else passed++;
    total++; if (empty1 !== 1'b1)   $display("FAIL rst_empty1 got %b want 1", empty1); else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx_start0 !== 1'b0 || empty0 !== 1'b1) $display("FAIL post_rst_idle got start=%b empty=%b want 0/1", tx_start0, empty0); else passed++;
  endtask

  task automatic test_single_byte();
    sent0.delete();
    wr0(8'h41);
    total++; if (tx_start0 !== 1'b0) $display("FAIL t1_start_early got %b want 0", tx_start0); else passed++;
    total++; if (level0 !== 6'd1)    $display("FAIL t1_level_written got %0d want 1", level0); else passed++;
    @(negedge clk);
    total++; if (tx_start0 !== 1'b1) $display("FAIL t1_start_latency got %b want 1", tx_start0); else passed++;
    total++; if (tx_data0 !== 8'h41) $display("FAIL t1_tx_data got %h want 41", tx_data0); else passed++;
    total++; if (level0 !== 6'd0)    $display("FAIL t1_level_popped got %0d want 0", level0); else passed++;
    wait_sent0(1);
    total++; if (sent0.size() !== 1) $display("FAIL t1_start_count got %0d want 1", sent0.size()); else passed++;
    total++; if (tx_data0 !== 8'h41) $display("FAIL t1_tx_data_held got %h want 41", tx_data0); else passed++;
  endtask

  task automatic test_full_overflow_wrap();
    sent0.delete();
    hold_busy0 = 1'b1;
    wr0(8'hEE);
    for (int i = 0; i < 32; i++) wr0(8'(i));
    total++; if (full0 !== 1'b1)   $display("FAIL t2_full got %b want 1", full0); else passed++;
    total++; if (level0 !== 6'd32) $display("FAIL t2_level_full got %0d want 32", level0); else passed++;
    total++; if (overflow0 !== 1'b0) $display("FAIL t2_overflow_idle got %b want 0", overflow0); else passed++;
    wr_en0 = 1'b1; wr_data0 = 8'h20;
    @(negedge clk);
    wr_en0 = 1'b0;
    total++; if (overflow0 !== 1'b1) $display("FAIL t2_overflow_pulse got %b want 1", overflow0); else passed++;
    total++; if (level0 !== 6'd32)   $display("FAIL t2_level_after_ovf got %0d want 32", level0); else passed++;
    @(negedge clk);
    total++; if (overflow0 !== 1'b0) $display("FAIL t2_overflow_one_cycle got %b want 0", overflow0); else passed++;
    total++; if (sent0.size() !== 1) $display("FAIL t2_stalled_sends got %0d want 1", sent0.size()); else passed++;
    hold_busy0 = 1'b0;
    wait_sent0(33);
    total++; if (sent0.size() !== 33) $display("FAIL t2_send_count got %0d want 33", sent0.size()); else passed++;
    total++; if (sent0[0] !== 8'hEE) $display("FAIL t2_first_byte got %h want ee", sent0[0]); else passed++;
    for (int i = 0; i < 32; i++) begin
      total++; if (sent0[i+1] !== 8'(i)) $display("FAIL t2_order[%0d] got %h want %h", i, sent0[i+1], 8'(i)); else passed++;
    end
    total++; if (empty0 !== 1'b1) $display("FAIL t2_empty_after got %b want 1", empty0); else passed++;
  endtask

  task automatic test_line_mode_eol();
    sent1.delete(); line_cnt1 = 0;
    wr1(8'h4F); wr1(8'h4B);
    repeat (10) @(negedge clk);
    total++; if (sent1.size() !== 0) $display("FAIL t3_held_sends got %0d want 0", sent1.size()); else passed++;
    total++; if (level1 !== 6'd2)    $display("FAIL t3_held_level got %0d want 2", level1); else passed++;
    wr1(8'h0A);
    wait_sent1(3);
    total++; if (sent1.size() !== 3) $display("FAIL t3_send_count got %0d want 3", sent1.size()); else passed++;
    total++; if (sent1[0] !== 8'h4F || sent1[1] !== 8'h4B || sent1[2] !== 8'h0A)
      $display("FAIL t3_order got %h %h %h want 4f 4b 0a", sent1[0], sent1[1], sent1[2]); else passed++;
    total++; if (line_cnt1 !== 1) $display("FAIL t3_line_sent got %0d want 1", line_cnt1); else passed++;
    total++; if (level1 !== 6'd0) $display("FAIL t3_level_after got %0d want 0", level1); else passed++;
  endtask

  task automatic test_line_mode_flush();
    sent1.delete(); line_cnt1 = 0;
    wr1(8'h41); wr1(8'h42);
    repeat (10) @(negedge clk);
    total++; if (sent1.size() !== 0) $display("FAIL t4_held_sends got %0d want 0", sent1.size()); else passed++;
    flush1 = 1'b1;
    @(negedge clk);
    flush1 = 1'b0;
    wait_sent1(2);
    total++; if (sent1.size() !== 2 || sent1[0] !== 8'h41 || sent1[1] !== 8'h42)
      $display("FAIL t4_flushed got n=%0d want 2 bytes 41 42", sent1.size()); else passed++;
    total++; if (line_cnt1 !== 0) $display("FAIL t4_line_sent got %0d want 0", line_cnt1); else passed++;
    wr1(8'h43);
    repeat (30) @(negedge clk);
    total++; if (sent1.size() !== 2) $display("FAIL t4_flush_cleared got %0d want 2", sent1.size()); else passed++;
    total++; if (level1 !== 6'd1)    $display("FAIL t4_level_held got %0d want 1", level1); else passed++;
  endtask

  task automatic test_back_to_back();
    sent0.delete();
    hold_busy0 = 1'b1;
    for (int i = 0; i < 6; i++) wr0(8'h50 + 8'(i));
    repeat (15) @(negedge clk);
    total++; if (level0 !== 6'd5) $display("FAIL t5_level_before got %0d want 5", level0); else passed++;
    hold_busy0 = 1'b0;
    @(negedge clk);
    wr_en0 = 1'b1; wr_data0 = 8'h56;
    @(negedge clk);
    wr_en0 = 1'b0;
    total++; if (level0 !== 6'd5)    $display("FAIL t5_level_same got %0d want 5", level0); else passed++;
    total++; if (tx_start0 !== 1'b1) $display("FAIL t5_pop_start got %b want 1", tx_start0); else passed++;
    wait_sent0(7);
    total++; if (sent0.size() !== 7) $display("FAIL t5_send_count got %0d want 7", sent0.size()); else passed++;
    for (int i = 0; i < 7; i++) begin
      total++; if (sent0[i] !== 8'h50 + 8'(i)) $display("FAIL t5_order[%0d] got %h want %h", i, sent0[i], 8'h50 + 8'(i)); else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    sent0.delete();
    hold_busy0 = 1'b1;
    for (int i = 0; i < 4; i++) wr0(8'h60 + 8'(i));
    repeat (5) @(negedge clk);
    total++; if (level0 !== 6'd3) $display("FAIL t6_level_queued got %0d want 3", level0); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (empty0 !== 1'b1)    $display("FAIL t6_empty got %b want 1", empty0); else passed++;
    total++; if (level0 !== 6'd0)    $display("FAIL t6_level got %0d want 0", level0); else passed++;
    total++; if (tx_start0 !== 1'b0) $display("FAIL t6_tx_start got %b want 0", tx_start0); else passed++;
    total++; if (level1 !== 6'd0)    $display("FAIL t6_level1 got %0d want 0", level1); else passed++;
    @(negedge clk);
    rst = 1'b0;
    sent0.delete();
    hold_busy0 = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (sent0.size() !== 0) $display("FAIL t6_no_start got %0d want 0", sent0.size()); else passed++;
    total++; if (empty0 !== 1'b1)    $display("FAIL t6_still_empty got %b want 1", empty0); else passed++;
  endtask

  initial begin
    line_cnt0 = 0; line_cnt1 = 0;
    test_reset();
    test_single_byte();
    test_full_overflow_wrap();
    test_line_mode_eol();
    test_line_mode_flush();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
